// File: rtl/lfsr8_checker.sv
// lfsr8_checker: self-synchronizing receive checker for the x^8+x^4+x^3+x^2+1 Galois PRBS stream.
// Seeds from received data, verifies LOCK_COUNT predictions, then flywheels and flags mismatching words.
module lfsr8_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             locked,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} st_e;
  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);
  st_e st_q, st_d;
  logic [7:0] pred_q, pred_d;
  logic [3:0] match_q, match_d, miss_q, miss_d;
  logic error_q, error_d;
  logic [CNT_W-1:0] ec_q, ec_d, wc_q, wc_d;
  logic hit;
  logic [3:0] match_inc, miss_inc;
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:4], s[3] ^ s[7], s[2] ^ s[7], s[1] ^ s[7], s[0], s[7]};
  endfunction
  assign hit       = in_data == pred_q;
  assign match_inc = match_q + 4'd1;
  assign miss_inc  = miss_q + 4'd1;
  always_comb begin
    st_d    = st_q;
    pred_d  = pred_q;
    match_d = match_q;
    miss_d  = miss_q;
    error_d = 1'b0;
    ec_d    = ec_q;
    wc_d    = wc_q;
    if (in_valid) begin
      case (st_q)
        HUNT: begin
          if (in_data != 8'h00) begin
            pred_d  = lfsr_next(in_data);
            match_d = '0;
            st_d    = VERIFY;
          end
        end
        VERIFY: begin
          if (in_data == 8'h00) st_d = HUNT;
          else begin
            pred_d  = lfsr_next(in_data);
            match_d = hit ? match_inc : '0;
            if (hit && match_inc == LOCK_N) begin
              st_d   = LOCKED;
              miss_d = '0;
            end
          end
        end
        LOCKED: begin
          // flywheel: prediction runs from its own state, not from received data
          pred_d = lfsr_next(pred_q);
          wc_d   = &wc_q ? wc_q : wc_q + CNT_W'(1);
          miss_d = hit ? '0 : miss_inc;
          if (!hit) begin
            error_d = 1'b1;
            ec_d    = &ec_q ? ec_q : ec_q + CNT_W'(1);
            if (miss_inc == LOSS_N) begin
              st_d    = HUNT;
              match_d = '0;
            end
          end
        end
        default: st_d = HUNT;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q    <= HUNT;
      pred_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      error_q <= 1'b0;
      ec_q    <= '0;
      wc_q    <= '0;
    end else begin
      st_q    <= st_d;
      pred_q  <= pred_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      error_q <= error_d;
      ec_q    <= ec_d;
      wc_q    <= wc_d;
    end
  end
  assign locked     = st_q == LOCKED;
  assign error      = error_q;
  assign err_count  = ec_q;
  assign word_count = wc_q;
  assign state      = st_q;
endmodule

// File: tb/tb_lfsr8_checker.sv
// tb_lfsr8_checker: table-driven lock/corruption vectors, then scoreboarded sequences against a reference model.
module tb_lfsr8_checker;
  logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic locked, error, locked_s, error_s;
  logic [15:0] err_count, word_count;
  logic [3:0] err_count_s, word_count_s;
  logic [1:0] state, state_s;
  int n_checks = 0, n_fail = 0;
  lfsr8_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .error(error), .err_count(err_count), .word_count(word_count), .state(state));
  lfsr8_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(4)) dut_s (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .locked(locked_s), .error(error_s), .err_count(err_count_s), .word_count(word_count_s), .state(state_s));
  always #5 clock = ~clock;
  typedef struct {logic v; logic [7:0] d; logic [1:0] st; logic lk; logic er; logic [15:0] ec; logic [15:0] wc;} vec_t;
  typedef struct {logic [1:0] st; logic er; logic [15:0] ec; logic [15:0] wc; logic [3:0] ecs; logic [3:0] wcs;} exp_t;
  vec_t tbl[11];
  exp_t sb[$];
  exp_t e_cur;
  int m_st, m_match, m_miss, m_ec, m_wc;
  logic [7:0] m_pred, g;
  bit m_er;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] nxt(input logic [7:0] s);
    return {s[6:0], s[7]} ^ (s[7] ? 8'h1C : 8'h00);
  endfunction
  function automatic int sat(input int x, input int mx);
    return x > mx ? mx : x;
  endfunction
  task automatic step(input bit r, input bit v, input logic [7:0] d);
    if (r) begin
      m_st = 0; m_pred = 8'h00; m_match = 0; m_miss = 0; m_ec = 0; m_wc = 0; m_er = 0;
    end else begin
      m_er = 0;
      if (v) begin
        if (m_st == 0) begin
          if (d != 8'h00) begin m_pred = nxt(d); m_match = 0; m_st = 1; end
        end else if (m_st == 1) begin
          if (d == 8'h00) m_st = 0;
          else if (d == m_pred) begin
            m_match++; m_pred = nxt(d);
            if (m_match == 4) begin m_st = 2; m_miss = 0; end
          end else begin m_pred = nxt(d); m_match = 0; end
        end else begin
          m_wc++;
          if (d != m_pred) begin
            m_er = 1; m_ec++; m_miss++;
            if (m_miss == 3) begin m_st = 0; m_match = 0; end
          end else m_miss = 0;
          m_pred = nxt(m_pred);
        end
      end
    end
  endtask
  task automatic drive(input bit r, input bit v, input logic [7:0] d);
    @(negedge clock);
    reset = r; in_valid = v; in_data = d;
    step(r, v, d);
    sb.push_back('{2'(m_st), m_er, 16'(sat(m_ec, 65535)), 16'(sat(m_wc, 65535)), 4'(sat(m_ec, 15)), 4'(sat(m_wc, 15))});
  endtask
  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin drive(0, 1, g); g = nxt(g); end
  endtask
  task automatic bad(input int n);
    for (int i = 0; i < n; i++) begin drive(0, 1, g ^ 8'h01); g = nxt(g); end
  endtask
  task automatic idle();
    drive(0, 0, 8'($urandom));
  endtask
  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      e_cur = sb.pop_front();
      chk("sb_state", state, e_cur.st);
      chk("sb_locked", locked, e_cur.st == 2'd2);
      chk("sb_error", error, e_cur.er);
      chk("sb_err_count", err_count, e_cur.ec);
      chk("sb_word_count", word_count, e_cur.wc);
      chk("sb_err_count_w4", err_count_s, e_cur.ecs);
      chk("sb_word_count_w4", word_count_s, e_cur.wcs);
    end
  end
  initial begin
    tbl[0]  = '{1'b1, 8'h01, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[1]  = '{1'b1, 8'h02, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[2]  = '{1'b1, 8'h04, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[3]  = '{1'b1, 8'h08, 2'd1, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[4]  = '{1'b1, 8'h10, 2'd2, 1'b1, 1'b0, 16'd0, 16'd0};
    tbl[5]  = '{1'b1, 8'h20, 2'd2, 1'b1, 1'b0, 16'd0, 16'd1};
    tbl[6]  = '{1'b1, 8'h40, 2'd2, 1'b1, 1'b0, 16'd0, 16'd2};
    tbl[7]  = '{1'b1, 8'h80, 2'd2, 1'b1, 1'b0, 16'd0, 16'd3};
    tbl[8]  = '{1'b1, 8'h1C, 2'd2, 1'b1, 1'b1, 16'd1, 16'd4};
    tbl[9]  = '{1'b0, 8'h00, 2'd2, 1'b1, 1'b0, 16'd1, 16'd4};
    tbl[10] = '{1'b1, 8'h3A, 2'd2, 1'b1, 1'b0, 16'd1, 16'd5};
    repeat (2) @(posedge clock);
    #1;
    chk("rst_state", state, 2'd0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_err_count", err_count, 16'd0);
    chk("rst_word_count", word_count, 16'd0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      reset = 1'b0; in_valid = tbl[i].v; in_data = tbl[i].d;
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
      chk($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
      chk($sformatf("tbl%0d_error", i), error, tbl[i].er);
      chk($sformatf("tbl%0d_err_count", i), err_count, tbl[i].ec);
      chk($sformatf("tbl%0d_word_count", i), word_count, tbl[i].wc);
    end
    drive(1, 0, 8'h00);
    repeat (8) drive(0, 1, 8'h00);
    drive(1, 0, 8'h00);
    g = 8'h01;
    clean(12);
    bad(3);
    clean(5);
    idle();
    @(posedge clock);
    #2;
    chk("relock_locked", locked, 1'b1);
    chk("relock_err_count", err_count, 16'd3);
    clean(3);
    for (int i = 0; i < 6; i++) begin clean(1); idle(); idle(); clean(1); end
    drive(1, 0, 8'h00);
    g = 8'h01;
    clean(6); bad(2); clean(1); bad(2); clean(1); bad(1);
    idle();
    @(posedge clock);
    #2;
    chk("pre_rst_locked", locked, 1'b1);
    chk("pre_rst_err_count", err_count, 16'd5);
    drive(1, 0, 8'h00);
    @(posedge clock);
    #2;
    chk("mid_rst_locked", locked, 1'b0);
    chk("mid_rst_err_count", err_count, 16'd0);
    chk("mid_rst_state", state, 2'd0);
    g = 8'h01;
    clean(6);
    for (int i = 0; i < 10; i++) begin bad(2); clean(1); end
    idle();
    @(posedge clock);
    #2;
    chk("sat_err_count_w16", err_count, 16'd20);
    chk("sat_err_count_w4", err_count_s, 4'd15);
    chk("sat_word_count_w4", word_count_s, 4'd15);
    chk("sat_locked", locked, 1'b1);
    repeat (3) @(posedge clock);
    #2;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
